// File: rtl/turn_score_ctrl_mp.sv
// N-player turn, countdown and score controller for the memory game.
// Rotates turns, times each turn, tallies pairs and resolves the winner by a sequential scan.
module turn_score_ctrl_mp #(
  parameter int unsigned NUM_PLAYERS    = 2,
  parameter int unsigned TOTAL_PAIRS    = 8,
  parameter int unsigned TICKS_PER_TURN = 300,
  parameter int unsigned SCORE_W        = 4,
  localparam int unsigned PW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1,
  localparam int unsigned TW = $clog2(TICKS_PER_TURN + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start_game,
  input  logic                           tick_en,
  input  logic                           pause,
  input  logic                           pair_matched,
  input  logic                           pair_missed,
  output logic                           game_active,
  output logic [PW-1:0]                  current_player,
  output logic [TW-1:0]                  time_left,
  output logic                           timeout_o,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores_o,
  output logic                           game_over,
  output logic [PW-1:0]                  winner,
  output logic                           tie
);

  localparam int unsigned CW = $clog2(TOTAL_PAIRS + 1);
  localparam logic [PW-1:0]      LastPlayer = PW'(NUM_PLAYERS - 1);
  localparam logic [TW-1:0]      Reload     = TW'(TICKS_PER_TURN);
  localparam logic [CW-1:0]      PairsEnd   = CW'(TOTAL_PAIRS);
  localparam logic [SCORE_W-1:0] ScoreSat   = '1;

  typedef enum logic [1:0] {StIdle, StRun, StResolve, StOver} state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        cur_q, cur_d;
  logic [TW-1:0]        time_q, time_d;
  logic [CW-1:0]        total_q, total_d;
  logic [SCORE_W-1:0]   score_q [NUM_PLAYERS];
  logic [SCORE_W-1:0]   score_d [NUM_PLAYERS];
  logic                 timeout_q, timeout_d;
  logic [PW-1:0]        idx_q, idx_d;
  logic [SCORE_W-1:0]   best_q, best_d;
  logic [PW-1:0]        scan_win_q, scan_win_d;
  logic                 scan_tie_q, scan_tie_d;
  logic [PW-1:0]        winner_q, winner_d;
  logic                 tie_q, tie_d;
  logic                 active_q, over_q;

  logic [PW-1:0]        nxt_player;
  logic [SCORE_W-1:0]   scan_score;
  logic [SCORE_W-1:0]   new_best;
  logic [PW-1:0]        new_win;
  logic                 new_tie;

  assign nxt_player = (cur_q == LastPlayer) ? '0 : cur_q + PW'(1);
  assign scan_score = score_q[idx_q];

  // Running max over the scan; the first entry seeds it, later equal scores flag a tie.
  always_comb begin
    new_best = best_q;
    new_win  = scan_win_q;
    new_tie  = scan_tie_q;
    if (idx_q == '0) begin
      new_best = scan_score;
      new_win  = '0;
      new_tie  = 1'b0;
    end else if (scan_score > best_q) begin
      new_best = scan_score;
      new_win  = idx_q;
      new_tie  = 1'b0;
    end else if (scan_score == best_q) begin
      new_tie  = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    time_d     = time_q;
    total_d    = total_q;
    score_d    = score_q;
    timeout_d  = 1'b0;
    idx_d      = idx_q;
    best_d     = best_q;
    scan_win_d = scan_win_q;
    scan_tie_d = scan_tie_q;
    winner_d   = winner_q;
    tie_d      = tie_q;

    if (start_game) begin
      state_d    = StRun;
      cur_d      = '0;
      time_d     = Reload;
      total_d    = '0;
      for (int p = 0; p < NUM_PLAYERS; p++) score_d[p] = '0;
      idx_d      = '0;
      best_d     = '0;
      scan_win_d = '0;
      scan_tie_d = 1'b0;
      winner_d   = '0;
      tie_d      = 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (pair_matched) begin
            if (score_q[cur_q] != ScoreSat) score_d[cur_q] = score_q[cur_q] + SCORE_W'(1);
            total_d = total_q + CW'(1);
            time_d  = Reload;
            if (total_d == PairsEnd) begin
              state_d = StResolve;
              idx_d   = '0;
            end
          end else if (pair_missed) begin
            cur_d  = nxt_player;
            time_d = Reload;
          end else if (tick_en && !pause) begin
            if (time_q == TW'(1)) begin
              timeout_d = 1'b1;
              cur_d     = nxt_player;
              time_d    = Reload;
            end else begin
              time_d = time_q - TW'(1);
            end
          end
        end
        StResolve: begin
          best_d     = new_best;
          scan_win_d = new_win;
          scan_tie_d = new_tie;
          if (idx_q == LastPlayer) begin
            state_d  = StOver;
            winner_d = new_win;
            tie_d    = new_tie;
          end else begin
            idx_d = idx_q + PW'(1);
          end
        end
        StIdle, StOver: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cur_q      <= '0;
      time_q     <= '0;
      total_q    <= '0;
      for (int p = 0; p < NUM_PLAYERS; p++) score_q[p] <= '0;
      timeout_q  <= 1'b0;
      idx_q      <= '0;
      best_q     <= '0;
      scan_win_q <= '0;
      scan_tie_q <= 1'b0;
      winner_q   <= '0;
      tie_q      <= 1'b0;
      active_q   <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      time_q     <= time_d;
      total_q    <= total_d;
      score_q    <= score_d;
      timeout_q  <= timeout_d;
      idx_q      <= idx_d;
      best_q     <= best_d;
      scan_win_q <= scan_win_d;
      scan_tie_q <= scan_tie_d;
      winner_q   <= winner_d;
      tie_q      <= tie_d;
      active_q   <= (state_d == StRun);
      over_q     <= (state_d == StOver);
    end
  end

  always_comb begin
    scores_o = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) scores_o[p*SCORE_W +: SCORE_W] = score_q[p];
  end

  assign game_active    = active_q;
  assign game_over      = over_q;
  assign current_player = cur_q;
  assign time_left      = time_q;
  assign timeout_o      = timeout_q;
  assign winner         = winner_q;
  assign tie            = tie_q;

endmodule

// File: tb/tb_turn_score_ctrl_mp.sv
// Bench for turn_score_ctrl_mp: directed scenarios plus random traffic against a rule-level model.
module tb_turn_score_ctrl_mp;

  localparam int NP = 3;
  localparam int TP = 8;
  localparam int TK = 300;
  localparam int SW = 4;
  localparam int PW = 2;
  localparam int TW = 9;
  localparam int VW = 4 + 2 * PW + TW + NP * SW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_game = 1'b0, tick_en = 1'b0, pause = 1'b0;
  logic pair_matched = 1'b0, pair_missed = 1'b0;
  logic game_active, timeout_o, game_over, tie;
  logic [PW-1:0] current_player, winner;
  logic [TW-1:0] time_left;
  logic [NP*SW-1:0] scores_o;

  int total_cnt = 0;
  int bad_cnt = 0;

  // Model state: 0 idle, 1 run, 2 resolve, 3 over
  int m_state, m_cur, m_time, m_total, m_rcnt, m_win;
  bit m_tie, m_to;
  int m_score [NP];

  always #5 clk = ~clk;

  turn_score_ctrl_mp #(
    .NUM_PLAYERS(NP), .TOTAL_PAIRS(TP), .TICKS_PER_TURN(TK), .SCORE_W(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_game(start_game), .tick_en(tick_en), .pause(pause),
    .pair_matched(pair_matched), .pair_missed(pair_missed), .game_active(game_active),
    .current_player(current_player), .time_left(time_left), .timeout_o(timeout_o),
    .scores_o(scores_o), .game_over(game_over), .winner(winner), .tie(tie)
  );

  function automatic void model_reset();
    m_state = 0; m_cur = 0; m_time = 0; m_total = 0; m_rcnt = 0; m_win = 0;
    m_tie = 0; m_to = 0;
    foreach (m_score[p]) m_score[p] = 0;
  endfunction

  function automatic void model_step(bit s, bit t, bit pz, bit m, bit x);
    int mx, n;
    m_to = 0;
    if (s) begin
      m_state = 1; m_cur = 0; m_time = TK; m_total = 0; m_win = 0; m_tie = 0;
      foreach (m_score[p]) m_score[p] = 0;
    end else if (m_state == 1) begin
      if (m) begin
        if (m_score[m_cur] < (1 << SW) - 1) m_score[m_cur]++;
        m_total++;
        m_time = TK;
        if (m_total == TP) begin m_state = 2; m_rcnt = NP; end
      end else if (x) begin
        m_cur = (m_cur + 1) % NP; m_time = TK;
      end else if (t && !pz) begin
        if (m_time == 1) begin m_to = 1; m_cur = (m_cur + 1) % NP; m_time = TK; end
        else m_time--;
      end
    end else if (m_state == 2) begin
      m_rcnt--;
      if (m_rcnt == 0) begin
        mx = 0;
        foreach (m_score[p]) if (m_score[p] > mx) mx = m_score[p];
        n = 0; m_win = -1;
        foreach (m_score[p]) if (m_score[p] == mx) begin
          n++;
          if (m_win < 0) m_win = p;
        end
        m_tie = (n > 1);
        m_state = 3;
      end
    end
  endfunction

  function automatic logic [NP*SW-1:0] exp_scores();
    logic [NP*SW-1:0] r;
    r = '0;
    foreach (m_score[p]) r[p*SW +: SW] = SW'(m_score[p]);
    return r;
  endfunction

  function automatic int dut_score(input int p);
    return int'(scores_o[p*SW +: SW]);
  endfunction

  task automatic cyc(input bit s, input bit t, input bit pz, input bit m, input bit x);
    start_game = s; tick_en = t; pause = pz; pair_matched = m; pair_missed = x;
    model_step(s, t, pz, m, x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    #2;
    total_cnt++;
    if ({game_active, game_over, timeout_o, tie, winner, current_player, time_left, scores_o}
        !== '0) begin
      bad_cnt++;
      $display("FAIL reset_outputs act=%h req=0", {game_active, game_over, timeout_o, tie,
               winner, current_player, time_left, scores_o});
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 1, 0, 1, 0);
    total_cnt++;
    if (game_active !== 1'b0 || dut_score(0) !== 0) begin
      bad_cnt++;
      $display("FAIL idle_ignores act=%b/%0d req=0/0", game_active, dut_score(0));
    end
  endtask

  task automatic test_timeout();
    bit early;
    cyc(1, 0, 0, 0, 0);
    total_cnt++;
    if (game_active !== 1'b1 || time_left !== TW'(TK) || current_player !== '0) begin
      bad_cnt++;
      $display("FAIL start act=%b/%0d/%0d req=1/%0d/0", game_active, time_left,
               current_player, TK);
    end
    early = 0;
    for (int i = 1; i < TK; i++) begin
      cyc(0, 1, 0, 0, 0);
      if (timeout_o !== 1'b0) early = 1;
    end
    total_cnt++;
    if (early || time_left !== TW'(1)) begin
      bad_cnt++;
      $display("FAIL countdown act=%0d early=%b req=1 early=0", time_left, early);
    end
    cyc(0, 1, 0, 0, 0);
    total_cnt++;
    if (timeout_o !== 1'b1 || current_player !== PW'(1) || time_left !== TW'(TK)) begin
      bad_cnt++;
      $display("FAIL expiry act=%b/%0d/%0d req=1/1/%0d", timeout_o, current_player,
               time_left, TK);
    end
    cyc(0, 0, 0, 0, 0);
    total_cnt++;
    if (timeout_o !== 1'b0) begin
      bad_cnt++;
      $display("FAIL timeout_width act=%b req=0", timeout_o);
    end
  endtask

  task automatic test_miss_wrap();
    cyc(1, 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 1);
      total_cnt++;
      if (current_player !== PW'(k % NP) || time_left !== TW'(TK)) begin
        bad_cnt++;
        $display("FAIL miss_wrap%0d act=%0d/%0d req=%0d/%0d", k, current_player, time_left,
                 k % NP, TK);
      end
    end
  endtask

  task automatic test_match_tick();
    cyc(1, 0, 0, 0, 0);
    for (int i = 1; i < TK; i++) cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 0);
    total_cnt++;
    if (dut_score(0) !== 1 || timeout_o !== 1'b0 || current_player !== '0 ||
        time_left !== TW'(TK)) begin
      bad_cnt++;
      $display("FAIL match_over_expiry act=%0d/%b/%0d/%0d req=1/0/0/%0d", dut_score(0),
               timeout_o, current_player, time_left, TK);
    end
  endtask

  task automatic test_pause();
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 50; i++) cyc(0, 1, 1, 0, 0);
    total_cnt++;
    if (time_left !== TW'(TK - 10)) begin
      bad_cnt++;
      $display("FAIL pause_hold act=%0d req=%0d", time_left, TK - 10);
    end
    cyc(0, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 0);
    total_cnt++;
    if (dut_score(0) !== 1 || time_left !== TW'(TK)) begin
      bad_cnt++;
      $display("FAIL pause_match act=%0d/%0d req=1/%0d", dut_score(0), time_left, TK);
    end
    cyc(0, 1, 0, 0, 0);
    total_cnt++;
    if (time_left !== TW'(TK - 1)) begin
      bad_cnt++;
      $display("FAIL unpause act=%0d req=%0d", time_left, TK - 1);
    end
  endtask

  task automatic test_win();
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);
    total_cnt++;
    if (game_active !== 1'b0 || game_over !== 1'b0) begin
      bad_cnt++;
      $display("FAIL resolve_entry act=%b/%b req=0/0", game_active, game_over);
    end
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 0);
    total_cnt++;
    if (game_over !== 1'b0) begin
      bad_cnt++;
      $display("FAIL resolve_len act=%b req=0", game_over);
    end
    cyc(0, 0, 0, 0, 0);
    total_cnt++;
    if (game_over !== 1'b1 || winner !== '0 || tie !== 1'b0 || current_player !== PW'(1)) begin
      bad_cnt++;
      $display("FAIL win act=%b/%0d/%b/%0d req=1/0/0/1", game_over, winner, tie,
               current_player);
    end
    cyc(0, 1, 0, 1, 0);
    cyc(0, 0, 0, 0, 1);
    total_cnt++;
    if (dut_score(0) !== 5 || dut_score(1) !== 3 || game_over !== 1'b1) begin
      bad_cnt++;
      $display("FAIL over_hold act=%0d/%0d/%b req=5/3/1", dut_score(0), dut_score(1),
               game_over);
    end
  endtask

  task automatic test_tie_restart();
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < NP; i++) cyc(0, 0, 0, 0, 0);
    total_cnt++;
    if (game_over !== 1'b1 || tie !== 1'b1 || winner !== '0) begin
      bad_cnt++;
      $display("FAIL tie act=%b/%b/%0d req=1/1/0", game_over, tie, winner);
    end
    cyc(1, 0, 0, 0, 0);
    total_cnt++;
    if (game_active !== 1'b1 || game_over !== 1'b0 || scores_o !== '0 || tie !== 1'b0) begin
      bad_cnt++;
      $display("FAIL restart act=%b/%b/%h/%b req=1/0/0/0", game_active, game_over, scores_o,
               tie);
    end
    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    total_cnt++;
    if ({game_active, game_over, timeout_o, tie, winner, current_player, time_left, scores_o}
        !== '0) begin
      bad_cnt++;
      $display("FAIL mid_reset act=%h req=0", {game_active, game_over, timeout_o, tie, winner,
               current_player, time_left, scores_o});
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [VW-1:0] act, expv;
    bit pz;
    pz = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(19) == 0) pz = ($urandom_range(3) == 0);
      cyc(($urandom_range(299) == 0) || c == 0, $urandom_range(1) == 1, pz,
          $urandom_range(7) == 0, $urandom_range(9) == 0);
      act  = {game_active, game_over, timeout_o, tie, winner, current_player, time_left,
              scores_o};
      expv = {m_state == 1, m_state == 3, m_to, m_tie, PW'(m_win), PW'(m_cur), TW'(m_time),
              exp_scores()};
      total_cnt++;
      if (act !== expv) begin
        bad_cnt++;
        $display("FAIL random cyc=%0d act=%h req=%h", c, act, expv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_miss_wrap();
    test_match_tick();
    test_pause();
    test_win();
    test_tie_restart();
    test_random();
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=running req=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
